// File: rtl/pipe_ctrl_step_3_5.sv
// rtl/pipe_ctrl_step_3_5.sv - step 3..5 control pipeline with RAW interlock and branch flush
module pipe_ctrl_step_3_5 #(
  parameter int                    OPCODE_W   = 6,
  parameter int                    REG_W      = 5,
  parameter logic [OPCODE_W-1:0]   NOP_OPCODE = 6'b111111,
  parameter int                    CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode_step_2,
  input  logic [REG_W-1:0]    rs_step_2,
  input  logic [REG_W-1:0]    rt_step_2,
  input  logic [REG_W-1:0]    rd_step_2,
  input  logic                branch_taken_step_3,
  output logic [OPCODE_W-1:0] opcode_step_3,
  output logic [OPCODE_W-1:0] opcode_step_4,
  output logic [OPCODE_W-1:0] opcode_step_5,
  output logic [REG_W-1:0]    wnum_step_3,
  output logic [REG_W-1:0]    wnum_step_4,
  output logic [REG_W-1:0]    wnum_step_5,
  output logic                is_hazzard,
  output logic                stall_pc_if,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_W-1:0] dst_step_2;
  logic             uses_rs;
  logic             uses_rt;
  logic             match_3;
  logic             match_4;

  // Decode step-2 destination and source usage; compare against in-flight writers in steps 3 and 4.
  // Step 5 writes the regfile in time for step-2 reads, so it is never checked.
  always_comb begin
    dst_step_2 = '0;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    unique case (opcode_step_2)
      OP_RTYPE: begin dst_step_2 = rd_step_2; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_ADDI:  begin dst_step_2 = rt_step_2; uses_rs = 1'b1; end
      OP_LW:    begin dst_step_2 = rt_step_2; uses_rs = 1'b1; end
      OP_BEQ:   begin uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_SW:    begin uses_rs = 1'b1; uses_rt = 1'b1; end
      default:  ;
    endcase
    match_3 = (wnum_step_3 != '0) &&
              ((uses_rs && (wnum_step_3 == rs_step_2)) || (uses_rt && (wnum_step_3 == rt_step_2)));
    match_4 = (wnum_step_4 != '0) &&
              ((uses_rs && (wnum_step_4 == rs_step_2)) || (uses_rt && (wnum_step_4 == rt_step_2)));
  end

  assign is_hazzard  = match_3 | match_4;
  assign stall_pc_if = is_hazzard & ~branch_taken_step_3;

  // Advance steps 3..5; step 3 takes a bubble on flush or stall, otherwise the decoded step-2 instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_step_3 <= NOP_OPCODE;
      opcode_step_4 <= NOP_OPCODE;
      opcode_step_5 <= NOP_OPCODE;
      wnum_step_3   <= '0;
      wnum_step_4   <= '0;
      wnum_step_5   <= '0;
      stall_cnt     <= '0;
    end else begin
      if (branch_taken_step_3) begin
        opcode_step_3 <= NOP_OPCODE;
        wnum_step_3   <= '0;
      end else if (is_hazzard) begin
        opcode_step_3 <= NOP_OPCODE;
        wnum_step_3   <= '0;
        if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        opcode_step_3 <= opcode_step_2;
        wnum_step_3   <= dst_step_2;
      end
      opcode_step_4 <= opcode_step_3;
      wnum_step_4   <= wnum_step_3;
      opcode_step_5 <= opcode_step_4;
      wnum_step_5   <= wnum_step_4;
    end
  end

endmodule
